seq_divider: RTL

- Multi-cycle restoring divider, one quotient bit per clock. Parametrised successor to the single-cycle divide/modulo block.
- Adds start/busy/done handshake, divide-by-zero detection and an optional signed mode.
- Sits between a register-loaded operand source and any consumer that waits on Done. Removes the wide combinational divide path from the critical timing path.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 26 ++
 rtl/seq_divider.sv | 117 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the iteration-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Counter must hold WIDTH-1 down to 0 with headroom for the decrement.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration. The new quotient bit is
// shifted into dvd_o[0], so the dividend register accumulates the quotient.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dvd_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           q_bit;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        shifted = {rem_i, dvd_i[WIDTH-1]};
        diff    = shifted - {1'b0, dsr_i};
        q_bit   = ~diff[WIDTH];
        rem_o   = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_o   = {dvd_i[WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (one quotient bit per clock) with start/busy/done
// handshake, divide-by-zero flag and optional two's-complement mode.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Go,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, dvd_q, dsr_q;
    logic             sq_q, sr_q, zero_q;
    logic [WIDTH-1:0] quo_q, rmd_q;
    logic             busy_q, done_q, dbz_q;

    logic             dvd_neg, dsr_neg;
    logic [WIDTH-1:0] dvd_mag, dsr_mag;
    logic [WIDTH-1:0] step_rem, step_dvd;
    logic [WIDTH-1:0] quo_d, rmd_d;

    assign dvd_neg = (SIGNED != 0) & Dividend[WIDTH-1];
    assign dsr_neg = (SIGNED != 0) & Divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -Dividend : Dividend;
    assign dsr_mag = dsr_neg ? -Divisor  : Divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .dvd_o (step_dvd)
    );

    // On a zero divisor dvd_q holds the raw dividend, which becomes the remainder.
    assign quo_d = zero_q ? '1    : (sq_q ? -dvd_q : dvd_q);
    assign rmd_d = zero_q ? dvd_q : (sr_q ? -rem_q : rem_q);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            zero_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Go) begin
                        busy_q <= 1'b1;
                        cnt_q  <= CNT_W'(WIDTH - 1);
                        rem_q  <= '0;
                        dsr_q  <= dsr_mag;
                        sq_q   <= dvd_neg ^ dsr_neg;
                        sr_q   <= dvd_neg;
                        if (Divisor == '0) begin
                            zero_q  <= 1'b1;
                            dvd_q   <= Dividend;
                            state_q <= S_FIX;
                        end else begin
                            zero_q  <= 1'b0;
                            dvd_q   <= dvd_mag;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= step_rem;
                    dvd_q <= step_dvd;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    quo_q   <= quo_d;
                    rmd_q   <= rmd_d;
                    dbz_q   <= zero_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Quotient  = quo_q;
    assign Remainder = rmd_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = dbz_q;

endmodule
